fft_agu: RTL and testbench
==========================

FFT_AGU -- requirements
Module: fft_agu

Interface
REQ-001 The block SHALL have parameter LOG2N, default 10, meaning log2 of FFT length N; legal range 2..15.
REQ-002 The block SHALL have parameter MEM_LAT, default 1, meaning the data-RAM and twiddle-ROM read latency in cycles.
REQ-003 The block SHALL have parameter BFU_LAT, default 4, meaning the butterfly unit's input-to-output latency in cycles.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a full in-place FFT.
REQ-007 busy  output  1  high while a transform is in progress.
REQ-008 done  output  1  one-cycle pulse marking completion.
REQ-009 stage  output  4  current stage index s.
REQ-010 rd_en  output  1  butterfly issue strobe to the RAM read ports and twiddle ROM.
REQ-011 rd_addr_a / rd_addr_b  output  LOG2N each  read addresses of butterfly inputs A and B.
REQ-012 tw_addr  output  LOG2N-1  twiddle ROM index, aligned with rd_en.
REQ-013 wr_en  output  1  write strobe for butterfly results.
REQ-014 wr_addr_a / wr_addr_b  output  LOG2N each  write addresses of A_out and B_out.

Function
REQ-015 Algorithm SHALL be radix-2 DIT, in place, with input already bit-reversed in RAM and output in natural order.
REQ-016 For stage s (0..LOG2N-1) and butterfly k (0..N/2-1), with half = 2^s and j = k mod half: rd_addr_a = (k div half)*2*half + j; rd_addr_b = rd_addr_a + half; tw_addr = j << (LOG2N-1-s).
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN on start=1, s=0, k=0; start in any other state is ignored.
REQ-019 RUN SHALL issue exactly one butterfly per cycle (rd_en=1), k incrementing; after k=N/2-1, go to DRAIN.
REQ-020 DRAIN SHALL last exactly D = MEM_LAT+BFU_LAT cycles with rd_en=0; then RUN with s+1, k=0, or DONE if s=LOG2N-1.
REQ-021 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-022 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by exactly D cycles, via a valid/address shift pipeline.
REQ-023 The last write of a stage SHALL occur in the final DRAIN cycle, so no read of stage s+1 precedes any write of stage s (no RAW hazard, no forwarding).
REQ-024 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE and DONE; busy cycles per transform = LOG2N*(N/2+D).
REQ-025 Outputs in IDLE SHALL be: rd_en=0, wr_en=0, all addresses 0, stage=0.
REQ-026 The issue counter SHALL never wrap inside a stage, and the stage counter SHALL never exceed LOG2N-1.

Reset
REQ-027 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and k, s, the delay-pipeline valids, busy, done, rd_en and wr_en SHALL all clear to 0.
REQ-028 Reset mid-transform SHALL abandon the transform: no wr_en in any later cycle from pre-reset issues, and no done pulse.
REQ-029 A start in the first cycle after reset release SHALL be accepted.

Configuration
REQ-030 Macro FFT_AGU_PERF_EN, when defined, SHALL add output cycle_cnt (32 bits), which clears to 0 on start acceptance, increments each busy cycle, holds in IDLE/DONE, and resets to 0.
REQ-031 Without FFT_AGU_PERF_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Test 1, LOG2N=3, D=5, start pulse: stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0; stage1 pairs (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 pairs (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
REQ-033 Test 2, same config: busy high for 27 cycles, done pulses once in cycle 28 after start, and cycle_cnt=27 with PERF_EN.
REQ-034 Test 3: each wr_en occurs exactly 5 cycles after its rd_en with identical addresses, and 12 writes in total.
REQ-035 Test 4: start held high continuously through a transform -> no restart until IDLE; a new transform begins the cycle after done.
REQ-036 Test 5: rst_n=0 for one cycle during stage1 RUN -> wr_en stays 0 afterwards, no done, and the next start runs a full correct sequence.
REQ-037 Test 6, LOG2N=10 golden model with BFU in loop: an impulse at index 0 -> all 1024 outputs equal within 1 LSB.

Source files
------------

// File: rtl/fft_agu.sv
// Address generator for an in-place radix-2 DIT FFT: issues butterfly reads and delayed writes per stage.
// Optional FFT_AGU_PERF_EN adds a 32-bit busy-cycle counter output cycle_cnt.
module fft_agu #(
  parameter int LOG2N   = 10,
  parameter int MEM_LAT = 1,
  parameter int BFU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
`ifdef FFT_AGU_PERF_EN
  ,
  output logic [31:0]      cycle_cnt
`endif
);

  localparam int D      = MEM_LAT + BFU_LAT;
  localparam int DW     = $clog2(D + 1);
  localparam int KW     = LOG2N - 1;
  localparam logic [3:0] LAST_S = 4'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k, k_nx;
  logic [3:0]      s, s_nx;
  logic [DW-1:0]   dcnt, dcnt_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      s     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      s     <= s_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // k parks at its last value through DRAIN and restarts at 0 only when the next stage begins.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    s_nx     = s;
    dcnt_nx  = dcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          k_nx     = '0;
          s_nx     = '0;
        end
      end
      RUN: begin
        if (k == '1) begin
          state_nx = DRAIN;
          dcnt_nx  = '0;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == DW'(D - 1)) begin
          if (s == LAST_S) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
            s_nx     = s + 1'b1;
            k_nx     = '0;
          end
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        k_nx     = '0;
        s_nx     = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Inserting a zero at bit s of k gives (k div half)*2*half + (k mod half).
  logic [LOG2N-1:0] half, mask, kx, addr_a;
  logic [KW-1:0]    j;

  always_comb begin
    half   = {{KW{1'b0}}, 1'b1} << s;
    mask   = half - 1'b1;
    kx     = {1'b0, k};
    addr_a = ((kx & ~mask) << 1) | (kx & mask);
    j      = k & mask[KW-1:0];
  end

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign stage     = s;
  assign rd_en     = (state == RUN);
  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? (addr_a | half) : '0;
  assign tw_addr   = rd_en ? (j << (4'(KW) - s)) : '0;

  logic [D-1:0]     vpipe;
  logic [LOG2N-1:0] apipe [D];
  logic [LOG2N-1:0] bpipe [D];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= rd_en;
      for (int unsigned i = 1; i < D; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    apipe[0] <= rd_addr_a;
    bpipe[0] <= rd_addr_b;
    for (int unsigned i = 1; i < D; i++) begin
      apipe[i] <= apipe[i-1];
      bpipe[i] <= bpipe[i-1];
    end
  end

  assign wr_en     = vpipe[D-1];
  assign wr_addr_a = wr_en ? apipe[D-1] : '0;
  assign wr_addr_b = wr_en ? bpipe[D-1] : '0;

`ifdef FFT_AGU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_agu.sv
// Scoreboard bench for fft_agu: small-N address/timing checks plus an N=1024 impulse run through a butterfly model.
module tb_fft_agu;
  localparam int L  = 3;
  localparam int N  = 8;
  localparam int D  = 5;
  localparam int BL = 10;
  localparam int BN = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start;
  logic           busy, done, rd_en, wr_en;
  logic [3:0]     stage;
  logic [L-1:0]   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [L-2:0]   tw_addr;
`ifdef FFT_AGU_PERF_EN
  logic [31:0]    cycle_cnt;
`endif

  logic           big_start;
  logic           big_busy, big_done, big_rd_en, big_wr_en;
  logic [3:0]     big_stage;
  logic [BL-1:0]  big_rd_a, big_rd_b, big_wr_a, big_wr_b;
  logic [BL-2:0]  big_tw;
`ifdef FFT_AGU_PERF_EN
  logic [31:0]    big_cycle_cnt;
`endif

  fft_agu #(.LOG2N(L), .MEM_LAT(1), .BFU_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef FFT_AGU_PERF_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  fft_agu #(.LOG2N(BL), .MEM_LAT(1), .BFU_LAT(4)) big (
    .clk(clk), .rst_n(rst_n), .start(big_start), .busy(big_busy), .done(big_done), .stage(big_stage),
    .rd_en(big_rd_en), .rd_addr_a(big_rd_a), .rd_addr_b(big_rd_b), .tw_addr(big_tw),
    .wr_en(big_wr_en), .wr_addr_a(big_wr_a), .wr_addr_b(big_wr_b)
`ifdef FFT_AGU_PERF_EN
    , .cycle_cnt(big_cycle_cnt)
`endif
  );

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  int     wr_cnt = 0;
  int     done_cnt = 0;

  typedef struct { logic [L-1:0] a; logic [L-1:0] b; logic [L-2:0] tw; logic [3:0] st; } rd_t;
  typedef struct { longint due; logic [L-1:0] a; logic [L-1:0] b; } wr_t;
  rd_t rq[$];
  wr_t wq[$];

  always @(posedge clk) cyc++;

  // Small-DUT scoreboard: reads popped against the address model, writes against the D-delayed copy.
  always @(negedge clk) begin
    rd_t e;
    wr_t w;
    if (done) done_cnt++;
    if (wr_en) begin
      total++;
      wr_cnt++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected cyc=%0d got a=%0d b=%0d required no write", cyc, wr_addr_a, wr_addr_b);
      end else begin
        w = wq.pop_front();
        if (w.due !== cyc || wr_addr_a !== w.a || wr_addr_b !== w.b) begin
          bad++;
          $display("FAIL wr_match got cyc=%0d a=%0d b=%0d required cyc=%0d a=%0d b=%0d",
                   cyc, wr_addr_a, wr_addr_b, w.due, w.a, w.b);
        end
      end
    end else if (wq.size() > 0 && wq[0].due <= cyc) begin
      total++;
      bad++;
      w = wq.pop_front();
      $display("FAIL wr_missing cyc=%0d got wr_en=0 required write a=%0d b=%0d", cyc, w.a, w.b);
    end
    if (rd_en) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected cyc=%0d got a=%0d b=%0d required no read", cyc, rd_addr_a, rd_addr_b);
        wq.push_back('{cyc + D, rd_addr_a, rd_addr_b});
      end else begin
        e = rq.pop_front();
        if (rd_addr_a !== e.a || rd_addr_b !== e.b || tw_addr !== e.tw || stage !== e.st) begin
          bad++;
          $display("FAIL rd_match got s=%0d a=%0d b=%0d tw=%0d required s=%0d a=%0d b=%0d tw=%0d",
                   stage, rd_addr_a, rd_addr_b, tw_addr, e.st, e.a, e.b, e.tw);
        end
        wq.push_back('{cyc + D, e.a, e.b});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq();
    int half, a;
    for (int s = 0; s < L; s++) begin
      half = 1 << s;
      for (int k = 0; k < N / 2; k++) begin
        a = (k / half) * 2 * half + (k % half);
        rq.push_back('{L'(a), L'(a + half), (L-1)'((k % half) << (L - 1 - s)), 4'(s)});
      end
    end
  endtask

  // ---------------- big model: RAM + twiddle ROM + butterfly ----------------
  longint ram_re [BN];
  longint ram_im [BN];
  longint tw_re [BN/2];
  longint tw_im [BN/2];
  typedef struct { int a; int b; longint ar; longint ai; longint br; longint bi; } bfu_t;
  bfu_t bq[$];

  always @(negedge clk) begin
    bfu_t r;
    longint tr, ti, wre, wim;
    if (big_wr_en) begin
      total++;
      if (bq.size() == 0) begin
        bad++;
        $display("FAIL big_wr_unexpected got a=%0d b=%0d required no write", big_wr_a, big_wr_b);
      end else begin
        r = bq.pop_front();
        if (int'(big_wr_a) != r.a || int'(big_wr_b) != r.b) begin
          bad++;
          $display("FAIL big_wr_addr got a=%0d b=%0d required a=%0d b=%0d", big_wr_a, big_wr_b, r.a, r.b);
        end
        ram_re[r.a] = r.ar; ram_im[r.a] = r.ai;
        ram_re[r.b] = r.br; ram_im[r.b] = r.bi;
      end
    end
    if (big_rd_en) begin
      wre = tw_re[big_tw];
      wim = tw_im[big_tw];
      tr = (ram_re[big_rd_b] * wre - ram_im[big_rd_b] * wim) >>> 14;
      ti = (ram_re[big_rd_b] * wim + ram_im[big_rd_b] * wre) >>> 14;
      r.a  = int'(big_rd_a);
      r.b  = int'(big_rd_b);
      r.ar = ram_re[big_rd_a] + tr;
      r.ai = ram_im[big_rd_a] + ti;
      r.br = ram_re[big_rd_a] - tr;
      r.bi = ram_im[big_rd_a] - ti;
      bq.push_back(r);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    int d0;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_done got busy=%b done=%b required 0 0", busy, done);
    end
    total++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes got rd_en=%b wr_en=%b required 0 0", rd_en, wr_en);
    end
    total++;
    if (stage !== 4'd0 || rd_addr_a !== '0 || rd_addr_b !== '0 || tw_addr !== '0 ||
        wr_addr_a !== '0 || wr_addr_b !== '0) begin
      bad++;
      $display("FAIL reset_addrs got stage=%0d ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d required all 0",
               stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b);
    end
`ifdef FFT_AGU_PERF_EN
    total++;
    if (cycle_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cycle_cnt got %0d required 0", cycle_cnt);
    end
`endif
    push_seq();
    d0 = done_cnt;
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || rd_en !== 1'b1) begin
      bad++;
      $display("FAIL start_after_release got busy=%b rd_en=%b required 1 1", busy, rd_en);
    end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_run_done_timeout got no done required done within 100 cycles");
    end
    tick();
  endtask

  task automatic test_addresses();
    int w0;
    bit seen;
    w0 = wr_cnt;
    push_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL addr_done_timeout got no done required done within 100 cycles");
    end
    repeat (2) tick();
    total++;
    if (rq.size() != 0 || wq.size() != 0) begin
      bad++;
      $display("FAIL addr_queues_drained got rd_left=%0d wr_left=%0d required 0 0", rq.size(), wq.size());
    end
    total++;
    if (wr_cnt - w0 != 12) begin
      bad++;
      $display("FAIL write_count got %0d required 12", wr_cnt - w0);
    end
  endtask

  task automatic test_timing();
    int nb, nd, done_at;
    push_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; nd = 0; done_at = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (done_at == 0) done_at = i;
      end
      tick();
    end
    total++;
    if (nb != 27) begin
      bad++;
      $display("FAIL busy_cycles got %0d required 27", nb);
    end
    total++;
    if (done_at != 28 || nd != 1) begin
      bad++;
      $display("FAIL done_pulse got cycle=%0d count=%0d required cycle=28 count=1", done_at, nd);
    end
`ifdef FFT_AGU_PERF_EN
    total++;
    if (cycle_cnt !== 32'd27) begin
      bad++;
      $display("FAIL cycle_cnt got %0d required 27", cycle_cnt);
    end
`endif
  endtask

  task automatic test_start_held();
    int nb;
    bit seen;
    push_seq();
    push_seq();
    start = 1'b1;
    tick();
    nb = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1;
      else tick();
    end
    total++;
    if (!seen || nb != 27) begin
      bad++;
      $display("FAIL held_first_run got done=%0d busy_cycles=%0d required 1 27", seen, nb);
    end
    tick();
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL held_idle_after_done got busy=%b rd_en=%b done=%b required 0 0 0", busy, rd_en, done);
    end
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || stage !== 4'd0) begin
      bad++;
      $display("FAIL held_restart got busy=%b rd_en=%b stage=%0d required 1 1 0", busy, rd_en, stage);
    end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL held_second_done_timeout got no done required done within 100 cycles");
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int d0, w0;
    bit seen;
    push_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (stage == 4'd1 && rd_en) seen = 1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_reach_stage1 got no stage1 issue required stage1 within 60 cycles");
    end
    tick();
    rst_n = 1'b0;
    tick();
    rq.delete();
    wq.delete();
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || stage !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_clear got busy=%b rd=%b wr=%b stage=%0d done=%b required 0 0 0 0 0",
               busy, rd_en, wr_en, stage, done);
    end
    rst_n = 1'b1;
    d0 = done_cnt;
    w0 = wr_cnt;
    repeat (30) tick();
    total++;
    if (wr_cnt != w0 || done_cnt != d0) begin
      bad++;
      $display("FAIL mid_abandon got writes=%0d dones=%0d required 0 0", wr_cnt - w0, done_cnt - d0);
    end
    w0 = wr_cnt;
    push_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    repeat (2) tick();
    total++;
    if (!seen || wr_cnt - w0 != 12 || rq.size() != 0 || wq.size() != 0) begin
      bad++;
      $display("FAIL mid_rerun got done=%0d writes=%0d rd_left=%0d wr_left=%0d required 1 12 0 0",
               seen, wr_cnt - w0, rq.size(), wq.size());
    end
  endtask

  task automatic test_golden();
    real ang, c, sn;
    bit seen;
    longint dr, di;
    for (int m = 0; m < BN / 2; m++) begin
      ang = 2.0 * 3.141592653589793 * real'(m) / real'(BN);
      c  = $cos(ang) * 16384.0;
      sn = -$sin(ang) * 16384.0;
      tw_re[m] = longint'($rtoi(c + ((c >= 0.0) ? 0.5 : -0.5)));
      tw_im[m] = longint'($rtoi(sn + ((sn >= 0.0) ? 0.5 : -0.5)));
    end
    for (int i = 0; i < BN; i++) begin
      ram_re[i] = 0;
      ram_im[i] = 0;
    end
    ram_re[0] = 1000;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      if (big_done) seen = 1;
      else tick();
    end
    total++;
    if (!seen || bq.size() != 0) begin
      bad++;
      $display("FAIL golden_done got done=%0d pending=%0d required 1 0", seen, bq.size());
    end
    for (int i = 0; i < BN; i++) begin
      dr = ram_re[i] - 1000;
      di = ram_im[i];
      total++;
      if (dr > 1 || dr < -1 || di > 1 || di < -1) begin
        bad++;
        $display("FAIL golden_out[%0d] got re=%0d im=%0d required re=1000 im=0 (+-1)", i, ram_re[i], ram_im[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    big_start = 1'b0;
    test_reset();
    test_addresses();
    test_timing();
    test_start_held();
    test_reset_mid();
    test_golden();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
